// File: rtl/id_ex_if.sv
// Decode-stage bus: IF/ID inputs, writeback port and ID/EX register outputs.
// master drives the decode inputs; slave is the decode stage itself.
interface id_ex_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned INSN_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic [INSN_W-1:0] IF_ID_IR;
    logic [DATA_W-1:0] IF_ID_NPC;
    logic              cond_stage;
    logic              WB_en;
    logic [ADDR_W-1:0] WB_rd;
    logic [DATA_W-1:0] WB_data;
    logic [INSN_W-1:0] ID_EX_IR;
    logic [DATA_W-1:0] ID_EX_NPC;
    logic [DATA_W-1:0] ID_EX_A;
    logic [DATA_W-1:0] ID_EX_B;
    logic [DATA_W-1:0] ID_EX_IMM;
    logic              ID_EX_VALID;
    logic              stall_id;

    modport master (
        output IF_ID_IR, IF_ID_NPC, cond_stage, WB_en, WB_rd, WB_data,
        input  ID_EX_IR, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_VALID, stall_id
    );

    modport slave (
        input  IF_ID_IR, IF_ID_NPC, cond_stage, WB_en, WB_rd, WB_data,
        output ID_EX_IR, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_VALID, stall_id
    );
endinterface

// File: rtl/id_ex_stage.sv
// Decode stage: register file with writeback bypass, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module id_ex_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic    clk1,
    input  logic    reset,
    id_ex_if.slave  bus
);
    localparam int unsigned REG_N  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned INSN_W = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [DATA_W-1:0] rf [REG_N];

    logic [INSN_W-1:0] ir;
    logic [6:0]        opcode;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] ld_rd;
    logic              use_rs1;
    logic              use_rs2;
    logic              load_use;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm;

    assign ir     = bus.IF_ID_IR;
    assign opcode = ir[6:0];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign ld_rd  = bus.ID_EX_IR[11:7];

    // Read port with same-cycle writeback forwarding; x0 is hardwired to zero
    function automatic logic [DATA_W-1:0] read_reg(
        input logic [ADDR_W-1:0] rs,
        input logic [DATA_W-1:0] stored,
        input logic              wb_en,
        input logic [ADDR_W-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        if (rs == '0)
            return '0;
        else if (wb_en && (wb_rd == rs))
            return wb_data;
        else
            return stored;
    endfunction

    always_comb begin
        rs1_val = read_reg(rs1, rf[rs1], bus.WB_en, bus.WB_rd, bus.WB_data);
        rs2_val = read_reg(rs2, rf[rs2], bus.WB_en, bus.WB_rd, bus.WB_data);
    end

    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        if ((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL))
            use_rs1 = 1'b0;
        if ((opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH))
            use_rs2 = 1'b1;
    end

    always_comb begin
        load_use = 1'b0;
        if (bus.ID_EX_VALID && (bus.ID_EX_IR[6:0] == OP_LOAD) && (ld_rd != '0))
            load_use = (use_rs1 && (rs1 == ld_rd)) || (use_rs2 && (rs2 == ld_rd));
    end

    // A taken branch discards the decoding instruction, so it can never stall
    assign bus.stall_id = load_use && !bus.cond_stage;

    always_comb begin
        imm = '0;
        unique case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm = DATA_W'($signed(ir[31:20]));
            OP_STORE:                 imm = DATA_W'($signed({ir[31:25], ir[11:7]}));
            OP_BRANCH:                imm = DATA_W'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
            OP_LUI, OP_AUIPC:         imm = DATA_W'({ir[31:12], 12'b0});
            OP_JAL:                   imm = DATA_W'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
            default:                  imm = '0;
        endcase
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_N; i++)
                rf[i] <= '0;
        end else if (bus.WB_en && (bus.WB_rd != '0)) begin
            rf[bus.WB_rd] <= bus.WB_data;
        end
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            bus.ID_EX_IR    <= NOP_INSN;
            bus.ID_EX_NPC   <= '0;
            bus.ID_EX_A     <= '0;
            bus.ID_EX_B     <= '0;
            bus.ID_EX_IMM   <= '0;
            bus.ID_EX_VALID <= 1'b0;
        end else if (bus.cond_stage || bus.stall_id) begin
            bus.ID_EX_IR    <= NOP_INSN;
            bus.ID_EX_NPC   <= '0;
            bus.ID_EX_A     <= '0;
            bus.ID_EX_B     <= '0;
            bus.ID_EX_IMM   <= '0;
            bus.ID_EX_VALID <= 1'b0;
        end else begin
            bus.ID_EX_IR    <= ir;
            bus.ID_EX_NPC   <= bus.IF_ID_NPC;
            bus.ID_EX_A     <= rs1_val;
            bus.ID_EX_B     <= rs2_val;
            bus.ID_EX_IMM   <= imm;
            bus.ID_EX_VALID <= 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: operand reads, bypass, immediates,
// load-use stalls, branch flush and asynchronous reset.
module tb_id_ex_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk1;
    logic reset;

    id_ex_if #(.DATA_W(32)) bus ();

    id_ex_stage #(.DATA_W(32), .NOP_INSN(NOP)) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        logic [31:0] ir;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        cond;
        logic        stall;
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ir, input logic wb_en, input logic [4:0] wb_rd,
                                input logic [31:0] wb_data, input logic cond, input logic stall,
                                input logic valid, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm);
        vec_t v;
        v.ir = ir; v.wb_en = wb_en; v.wb_rd = wb_rd; v.wb_data = wb_data; v.cond = cond;
        v.stall = stall; v.valid = valid; v.a = a; v.b = b; v.imm = imm;
        return v;
    endfunction

    task automatic drive(input logic [31:0] ir, input logic [31:0] npc, input logic wb_en,
                         input logic [4:0] wb_rd, input logic [31:0] wb_data, input logic cond);
        bus.IF_ID_IR   = ir;
        bus.IF_ID_NPC  = npc;
        bus.WB_en      = wb_en;
        bus.WB_rd      = wb_rd;
        bus.WB_data    = wb_data;
        bus.cond_stage = cond;
    endtask

    initial begin
        //                 ir            wb rd  wb_data       cond stall valid a             b             imm
        vecs[0]  = mk(32'h00028333, 0, 0,  32'h0,        0, 0, 1, 32'h0,        32'h0,  32'h0);
        vecs[1]  = mk(32'h00000013, 1, 5,  32'hDEADBEEF, 0, 0, 1, 32'h0,        32'h0,  32'h0);
        vecs[2]  = mk(32'h00028333, 0, 0,  32'h0,        0, 0, 1, 32'hDEADBEEF, 32'h0,  32'h0);
        vecs[3]  = mk(32'hFFF38413, 1, 7,  32'h12345678, 0, 0, 1, 32'h12345678, 32'h0,  32'hFFFFFFFF);
        vecs[4]  = mk(32'h0000A483, 1, 1,  32'h00000100, 0, 0, 1, 32'h100,      32'h0,  32'h0);
        vecs[5]  = mk(32'h00248533, 1, 2,  32'h00000022, 0, 1, 0, 32'h0,        32'h0,  32'h0);
        vecs[6]  = mk(32'h00248533, 0, 0,  32'h0,        0, 0, 1, 32'h0,        32'h22, 32'h0);
        vecs[7]  = mk(32'h0000A003, 0, 0,  32'h0,        0, 0, 1, 32'h100,      32'h0,  32'h0);
        vecs[8]  = mk(32'h000005B3, 0, 0,  32'h0,        0, 0, 1, 32'h0,        32'h0,  32'h0);
        vecs[9]  = mk(32'h0000A483, 0, 0,  32'h0,        0, 0, 1, 32'h100,      32'h0,  32'h0);
        vecs[10] = mk(32'h00048637, 0, 0,  32'h0,        0, 0, 1, 32'h0,        32'h0,  32'h00048000);
        vecs[11] = mk(32'hFE20AE23, 0, 0,  32'h0,        0, 0, 1, 32'h100,      32'h22, 32'hFFFFFFFC);
        vecs[12] = mk(32'h00208463, 0, 0,  32'h0,        0, 0, 1, 32'h100,      32'h22, 32'h8);
        vecs[13] = mk(32'hFFFFF0EF, 0, 0,  32'h0,        0, 0, 1, 32'h0,        32'h0,  32'hFFFFFFFE);
        vecs[14] = mk(32'h0000A483, 0, 0,  32'h0,        0, 0, 1, 32'h100,      32'h0,  32'h0);
        vecs[15] = mk(32'h00248533, 0, 0,  32'h0,        1, 0, 0, 32'h0,        32'h0,  32'h0);
        vecs[16] = mk(32'h00248533, 0, 0,  32'h0,        0, 0, 1, 32'h0,        32'h22, 32'h0);
        vecs[17] = mk(32'h000006B3, 1, 0,  32'hFFFFFFFF, 0, 0, 1, 32'h0,        32'h0,  32'h0);
        vecs[18] = mk(32'h000006B3, 0, 0,  32'h0,        0, 0, 1, 32'h0,        32'h0,  32'h0);
        vecs[19] = mk(32'h0000A483, 0, 0,  32'h0,        0, 0, 1, 32'h100,      32'h0,  32'h0);
        vecs[20] = mk(32'h0090A023, 0, 0,  32'h0,        0, 1, 0, 32'h0,        32'h0,  32'h0);
        vecs[21] = mk(32'h0090A023, 0, 0,  32'h0,        0, 0, 1, 32'h100,      32'h0,  32'h0);

        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        repeat (2) @(negedge clk1);
        #1;
        chk("reset_ir",    bus.ID_EX_IR, NOP);
        chk("reset_valid", 32'(bus.ID_EX_VALID), 32'h0);
        chk("reset_a",     bus.ID_EX_A, 32'h0);
        chk("reset_npc",   bus.ID_EX_NPC, 32'h0);
        @(negedge clk1);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk1);
            drive(vecs[i].ir, 32'(i * 4), vecs[i].wb_en, vecs[i].wb_rd, vecs[i].wb_data, vecs[i].cond);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(bus.stall_id), 32'(vecs[i].stall));
            @(posedge clk1);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(bus.ID_EX_VALID), 32'(vecs[i].valid));
            chk($sformatf("v%0d_ir", i),    bus.ID_EX_IR,  vecs[i].valid ? vecs[i].ir : NOP);
            chk($sformatf("v%0d_npc", i),   bus.ID_EX_NPC, vecs[i].valid ? 32'(i * 4) : 32'h0);
            chk($sformatf("v%0d_a", i),     bus.ID_EX_A,   vecs[i].a);
            chk($sformatf("v%0d_b", i),     bus.ID_EX_B,   vecs[i].b);
            chk($sformatf("v%0d_imm", i),   bus.ID_EX_IMM, vecs[i].imm);
        end

        // Asynchronous reset between clock edges, then register file must be cleared
        @(negedge clk1);
        drive(32'h00028333, 32'h0000_0100, 1'b0, 5'd0, 32'h0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_ir",    bus.ID_EX_IR, NOP);
        chk("midrst_valid", 32'(bus.ID_EX_VALID), 32'h0);
        chk("midrst_a",     bus.ID_EX_A, 32'h0);
        chk("midrst_npc",   bus.ID_EX_NPC, 32'h0);
        @(negedge clk1);
        reset = 1'b1;
        @(posedge clk1);
        #1;
        chk("postrst_valid", 32'(bus.ID_EX_VALID), 32'h1);
        chk("postrst_x5",    bus.ID_EX_A, 32'h0);
        chk("postrst_npc",   bus.ID_EX_NPC, 32'h0000_0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
